lsu_mem_initiator: RTL and testbench
====================================

// Module: lsu_mem_initiator
// PURPOSE
//  Initiator side of the byte-addressed memory port: takes one load/store request at a time from the
//  pipeline. Drives addr/wdata/wen/ren/wbyte for one cycle and waits out the memory's registered
//  1-cycle read. Extracts and extends load data, then returns a held response to the pipeline.
//  Sits between the EXU/LSU stage and the unified memory.
// PARAMETERS
//  ADDR_WIDTH  32     byte address width
//  DATA_WIDTH  8      memory cell (byte) width; bus width = 4*DATA_WIDTH
//  MEM_BYTES   65536  addressable bytes; accesses touching >= MEM_BYTES are errors
// PORTS
//  clk          in   1          clock, all state on posedge
//  rst          in   1          asynchronous, active-high reset
//  req_valid    in   1          pipeline request valid
//  req_ready    out  1          block idle, request accepted on valid&&ready edge
//  req_we       in   1          1 store, 0 load
//  req_size     in   2          00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1          load zero-extend (1) / sign-extend (0)
//  req_addr     in   ADDR_WIDTH byte address
//  req_wdata    in   4*DW       store data, LSB-aligned
//  resp_valid   out  1          response valid, held until resp_ready
//  resp_ready   in   1          pipeline consumes response
//  resp_rdata   out  4*DW       extended load data; 0 for stores/errors
//  resp_err     out  1          access rejected, no memory access performed
//  mem_addr     out  ADDR_WIDTH memory byte address
//  mem_wdata    out  4*DW       memory write data
//  mem_wen      out  1          memory write strobe
//  mem_ren      out  1          memory read strobe
//  mem_wbyte    out  2          00 1B, 01 2B, 11 4B
//  mem_rdata    in   4*DW       bytes addr..addr+3, valid the cycle after mem_ren
// BEHAVIOUR
//  Reset (async): state IDLE; req_ready=1 after release; resp_valid=0, resp_err=0, resp_rdata=0.
//   mem_wen=mem_ren=0 immediately on assertion, so no partial write survives reset mid-op.
//  FSM IDLE->ISSUE->(CAPTURE)->RESP->IDLE. IDLE: req_ready=1; on accept, register we/size/unsigned/addr/wdata.
//  ISSUE (1 cycle): if illegal -> RESP with err=1, no strobe. Store -> mem_wen=1 -> RESP.
//   Load -> mem_ren=1 -> CAPTURE. mem_wen and mem_ren never both high; both 0 outside ISSUE.
//  mem_addr/mem_wdata/mem_wbyte are driven from registered fields (stable in ISSUE, 0 in IDLE).
//  CAPTURE: sample mem_rdata. B uses [7:0], H uses [15:0], W uses all bits. Extend per req_unsigned -> RESP.
//  RESP: resp_valid=1 and outputs held stable until resp_ready; then IDLE (next req takes >=1 more cycle).
//  Latency accept-edge to resp_valid: load 3 cycles, store 2, error 2. Throughput 1 req per >=3 cycles.
//  Illegal: req_size==11; addr+nbytes > MEM_BYTES, computed in ADDR_WIDTH+1 bits (no wrap).
//  req_valid while busy is ignored (req_ready=0); resp_ready outside RESP is ignored.
// CONFIGURATION
//  MISALIGN_CHECK_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0 is illegal.
//   Illegal access -> resp_err=1, no strobe.
//  Undefined: misaligned accesses pass through unchanged (memory is byte-addressed, handles them).
// STRUCTURE
//  Package lsu_pkg: size codes SZ_B/SZ_H/SZ_W, wbyte codes WB_1/WB_2/WB_4 (00/01/11), FSM state enum.
//  Sub-module lsu_load_align: combinational mem_rdata+size+unsigned -> extended word.
//  Instantiated once, feeds the CAPTURE register.
// TESTING
//  Store W 0xDEADBEEF @0x10 -> mem_wen=1 one cycle with wbyte=11; then load W @0x10 -> rdata 0xDEADBEEF, err=0.
//  Load B @0x13 signed (byte 0xDE) -> 0xFFFFFFDE; unsigned -> 0x000000DE. Load H @0x12 signed -> 0xFFFFDEAD.
//  Store H 0x1234 @0x20 (wbyte=01) then load W @0x20 -> upper 16 bits untouched from prior contents.
//  Load W @0xFFFE (MEM_BYTES=65536) -> resp_err=1, rdata 0, mem_ren never high. req_size=11 -> err.
//  With MISALIGN_CHECK_EN: load W @0x11 -> err=1. Without it: load W @0x11 returns bytes 0x11..0x14.
//  Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0. Assert rst during ISSUE of a store.
//   -> wen drops asynchronously, FSM returns to IDLE, memory unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: size/wbyte codes, FSM states and byte-count helpers for the LSU memory initiator.
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;
  localparam logic [1:0] WB_1 = 2'b00;
  localparam logic [1:0] WB_2 = 2'b01;
  localparam logic [1:0] WB_4 = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_e;
  function automatic logic [1:0] wbyte_of(input logic [1:0] sz);
    return sz == SZ_B ? WB_1 : sz == SZ_H ? WB_2 : WB_4;
  endfunction
  function automatic logic [2:0] nbytes_of(input logic [1:0] sz);
    return sz == SZ_B ? 3'd1 : sz == SZ_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the low byte/half/word of the memory read data and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [4*DW-1:0] rdata_i,
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  output logic [4*DW-1:0] ext_o
);
  logic s;
  always_comb begin
    s = ~uns_i & (size_i == SZ_B ? rdata_i[DW-1] : rdata_i[2*DW-1]);
    ext_o = size_i == SZ_B ? {{(3*DW){s}}, rdata_i[DW-1:0]} :
            size_i == SZ_H ? {{(2*DW){s}}, rdata_i[2*DW-1:0]} : rdata_i;
  end
endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: single-outstanding load/store initiator for the byte-addressed memory port.
// Define MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_BYTES  = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [4*DATA_WIDTH-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [4*DATA_WIDTH-1:0] resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [4*DATA_WIDTH-1:0] mem_wdata,
  output logic                    mem_wen,
  output logic                    mem_ren,
  output logic [1:0]              mem_wbyte,
  input  logic [4*DATA_WIDTH-1:0] mem_rdata
);
  localparam int BW = 4*DATA_WIDTH;
  state_e state_q, state_d;
  logic we_q, uns_q, err_q, illegal, misal, accept, active;
  logic [1:0] size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0] wdata_q, rdata_q, ext;
  logic [ADDR_WIDTH:0] end_a;
  lsu_load_align #(.DW(DATA_WIDTH)) u_align (
    .rdata_i(mem_rdata),
    .size_i (size_q),
    .uns_i  (uns_q),
    .ext_o  (ext)
  );
`ifdef MISALIGN_CHECK_EN
  assign misal = (size_q == SZ_H && addr_q[0]) || (size_q == SZ_W && addr_q[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif
  // End address is one bit wider than the address so a top-of-space access cannot wrap to legal.
  assign end_a   = {1'b0, addr_q} + (ADDR_WIDTH+1)'(nbytes_of(size_q));
  assign illegal = size_q == SZ_X || end_a > (ADDR_WIDTH+1)'(MEM_BYTES) || misal;
  assign accept  = state_q == S_IDLE && req_valid;
  assign active  = state_q != S_IDLE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = req_valid ? S_ISSUE : S_IDLE;
      S_ISSUE:   state_d = (illegal || we_q) ? S_RESP : S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    state_d = resp_ready ? S_IDLE : S_RESP;
      default:   state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (state_q == S_ISSUE) err_q <= illegal;
      if (state_q == S_CAPTURE) rdata_q <= ext;
    end
  end
  // Strobes decode straight from state so an async reset kills them without waiting for an edge.
  assign req_ready  = state_q == S_IDLE;
  assign resp_valid = state_q == S_RESP;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;
  assign mem_wen    = state_q == S_ISSUE && we_q && !illegal;
  assign mem_ren    = state_q == S_ISSUE && !we_q && !illegal;
  assign mem_addr   = active ? addr_q : '0;
  assign mem_wdata  = active ? wdata_q : '0;
  assign mem_wbyte  = active ? wbyte_of(size_q) : WB_1;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed load/store vectors against a byte-array memory with 1-cycle registered reads.
module tb_lsu_mem_initiator;
  logic clk = 1'b0, rst = 1'b1, preload = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic req_ready, resp_valid, resp_err, mem_wen, mem_ren;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [1:0] mem_wbyte, last_wb = 2'b00;
  logic [7:0] mem [0:65539];
  int checks = 0, errors = 0, wen_cnt = 0, ren_cnt = 0, both_cnt = 0;

  lsu_mem_initiator dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_wbyte(mem_wbyte), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 65540; i++) mem[i] <= 8'h00;
      mem[32'h20] <= 8'hAA; mem[32'h21] <= 8'hBB; mem[32'h22] <= 8'hCC; mem[32'h23] <= 8'hDD;
      mem[32'hFFFC] <= 8'h01; mem[32'hFFFD] <= 8'h02; mem[32'hFFFE] <= 8'h03; mem[32'hFFFF] <= 8'h04;
    end else begin
      if (mem_wen && mem_addr < 32'd65536)
        for (int i = 0; i < 4; i++)
          if (i < (mem_wbyte == 2'b00 ? 1 : mem_wbyte == 2'b01 ? 2 : 4))
            mem[mem_addr[16:0] + 17'(i)] <= mem_wdata[8*i +: 8];
      if (mem_ren && mem_addr < 32'd65536)
        mem_rdata <= {mem[mem_addr[16:0] + 17'd3], mem[mem_addr[16:0] + 17'd2],
                      mem[mem_addr[16:0] + 17'd1], mem[mem_addr[16:0]]};
    end
  end

  always @(posedge clk) begin
    if (mem_wen) begin wen_cnt <= wen_cnt + 1; last_wb <= mem_wbyte; end
    if (mem_ren) ren_cnt <= ren_cnt + 1;
    if (mem_wen && mem_ren) both_cnt <= both_cnt + 1;
  end

  function automatic logic [31:0] memw(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input int hold);
    int lat, w0, r0;
    logic [31:0] rd;
    w0 = wen_cnt; r0 = ren_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, " lat"}, 32'(lat), (we || exp_err) ? 32'd2 : 32'd3);
    rd = resp_rdata;
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " hold rdata"}, resp_rdata, rd);
      chk({tag, " hold ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, " idle"}, {30'd0, req_ready, resp_valid}, 32'd2);
    chk({tag, " wen cnt"}, 32'(wen_cnt - w0), (we && !exp_err) ? 32'd1 : 32'd0);
    chk({tag, " ren cnt"}, 32'(ren_cnt - r0), (!we && !exp_err) ? 32'd1 : 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("rst strobes", {30'd0, mem_wen, mem_ren}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst resp", {resp_rdata[30:0], resp_valid}, 32'd0);
    chk("rst err", 32'(resp_err), 32'd0);
    req("st_w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    chk("st_w wbyte", 32'(last_wb), 32'd3);
    chk("st_w mem", memw(32'h10), 32'hDEADBEEF);
    req("ld_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    req("ld_b_s", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
    req("ld_b_u", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 0);
    req("ld_h_s", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
    req("ld_h_u", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 0);
    req("st_h", 1'b1, 2'b01, 1'b0, 32'h20, 32'hFFFF1234, 32'h0, 1'b0, 0);
    chk("st_h wbyte", 32'(last_wb), 32'd1);
    req("ld_w20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDDCC1234, 1'b0, 0);
    req("ld_oob", 1'b0, 2'b10, 1'b0, 32'hFFFE, 32'h0, 32'h0, 1'b1, 0);
    req("ld_top", 1'b0, 2'b10, 1'b0, 32'hFFFC, 32'h0, 32'h04030201, 1'b0, 0);
    req("ld_wrap", 1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 0);
    req("ld_sz3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    req("st_oob", 1'b1, 2'b10, 1'b0, 32'hFFFF, 32'h11223344, 32'h0, 1'b1, 0);
    chk("st_oob mem", memw(32'hFFFC), 32'h04030201);
`ifdef MISALIGN_CHECK_EN
    req("ld_mis", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 0);
`else
    req("ld_mis", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h00DEADBE, 1'b0, 0);
`endif
    req("hold", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid wen pre", 32'(mem_wen), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid wen", 32'(mem_wen), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid idle", {30'd0, req_ready, resp_valid}, 32'd2);
    chk("rst_mid mem", memw(32'h30), 32'h0);
    req("post_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    chk("both strobes", 32'(both_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
